// File: rtl/softmax_norm_ctrl_if.sv
// Exp-buffer read port, divider handshake and result stream of the softmax normaliser.
interface softmax_norm_ctrl_if #(
  parameter int unsigned AW = 3
) ();
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          div_clr;
  logic [31:0]   div_a;
  logic [31:0]   div_b;
  logic          div_a_strb;
  logic          div_b_strb;
  logic [31:0]   div_z;
  logic          div_z_strb;
  logic          div_z_ack;
  logic [31:0]   res_data;
  logic [AW-1:0] res_idx;
  logic          res_vld;
  logic          res_rdy;

  // Controller side
  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output div_clr, div_a, div_b, div_a_strb, div_b_strb,
    input  div_z, div_z_strb,
    output div_z_ack,
    output res_data, res_idx, res_vld,
    input  res_rdy
  );

  // Exp buffer, divider and downstream side
  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  div_clr, div_a, div_b, div_a_strb, div_b_strb,
    output div_z, div_z_strb,
    input  div_z_ack,
    input  res_data, res_idx, res_vld,
    output res_rdy
  );
endinterface

// File: rtl/softmax_norm_ctrl.sv
// Softmax normalisation sequencer: reads N exponentials, divides each by the
// captured sum on the shared strobe-handshake divider, streams quotients out.
module softmax_norm_ctrl #(
  parameter int unsigned N       = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [31:0]               sum,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  softmax_norm_ctrl_if.master       bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t        state_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] idx_d;
  logic [31:0]   sum_q;
  logic [TW-1:0] timer_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic          div_clr_q;
  logic [31:0]   div_a_q;
  logic [31:0]   div_b_q;
  logic          strb_q;
  logic [31:0]   res_data_q;
  logic [AW-1:0] res_idx_q;
  logic          res_vld_q;

  logic          last_c;
  logic          tmo_c;
  logic          sum_zero_c;

  // Next index and per-state decision flags
  assign idx_d      = idx_q + AW'(1);
  assign last_c     = (idx_q == AW'(N - 1));
  assign tmo_c      = (timer_q == TW'(TIMEOUT - 1));
  assign sum_zero_c = (sum[30:23] == 8'd0);

  // Main sequencer: state, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      sum_q      <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      div_clr_q  <= 1'b0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      strb_q     <= 1'b0;
      res_data_q <= '0;
      res_idx_q  <= '0;
      res_vld_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      div_clr_q <= 1'b0;
      strb_q    <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        // Abort beats everything; clear flushes any in-flight divide
        state_q   <= S_IDLE;
        busy_q    <= 1'b0;
        res_vld_q <= 1'b0;
        div_clr_q <= 1'b0 | 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              sum_q   <= sum;
              idx_q   <= '0;
              err_q   <= sum_zero_c;
              timer_q <= '0;
              if (sum_zero_c) begin
                done_q <= 1'b1;
              end else begin
                state_q   <= S_RD;
                busy_q    <= 1'b1;
                rd_en_q   <= 1'b1;
                rd_addr_q <= '0;
                div_clr_q <= 1'b1;
              end
            end
          end
          S_RD: begin
            state_q <= S_ISSUE;
            strb_q  <= 1'b1;
            div_b_q <= sum_q;
          end
          S_ISSUE: begin
            state_q <= S_WAIT;
            div_a_q <= bus.rd_data;
            timer_q <= '0;
          end
          S_WAIT: begin
            timer_q <= timer_q + TW'(1);
            if (bus.div_z_strb) begin
              res_data_q <= bus.div_z;
              res_idx_q  <= idx_q;
              res_vld_q  <= 1'b1;
              state_q    <= S_OUT;
            end else if (tmo_c) begin
              res_data_q <= '0;
              res_idx_q  <= idx_q;
              res_vld_q  <= 1'b1;
              err_q      <= 1'b1;
              state_q    <= S_OUT;
            end
          end
          S_OUT: begin
            if (bus.res_rdy) begin
              res_vld_q <= 1'b0;
              if (last_c) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q     <= idx_d;
                state_q   <= S_RD;
                rd_en_q   <= 1'b1;
                rd_addr_q <= idx_d;
                div_clr_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.div_clr    = div_clr_q;
  assign bus.div_b      = div_b_q;
  assign bus.div_a_strb = strb_q;
  assign bus.div_b_strb = strb_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_idx    = res_idx_q;
  assign bus.res_vld    = res_vld_q;

  // Read data only arrives in ISSUE, so the dividend passes straight through
  // there and is held from the captured copy afterwards
  assign bus.div_a = (state_q == S_ISSUE) ? bus.rd_data : div_a_q;

  // Ack is the one output allowed to follow the divider strobe directly
  assign bus.div_z_ack = (state_q == S_WAIT) && bus.div_z_strb;

endmodule

// File: tb/tb_softmax_norm_ctrl.sv
// Self-checking bench for softmax_norm_ctrl with exp-buffer and divider models.
module tb_softmax_norm_ctrl;
  localparam int unsigned N       = 8;
  localparam int unsigned AW      = 3;
  localparam int unsigned TIMEOUT = 64;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] sum;
  logic        busy;
  logic        done;
  logic        err;

  softmax_norm_ctrl_if #(.AW(AW)) bus ();

  softmax_norm_ctrl #(.N(N), .AW(AW), .TIMEOUT(TIMEOUT), .TW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sum(sum),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Test configuration
  logic [31:0] mem [N];
  int          lat;
  bit          stuck;
  int          hang_idx;
  int          rdy_mode;
  int          hold_left;
  logic [AW-1:0] last_addr;

  // Scoreboard counters
  int n_cmp;
  int n_bad;

  // Monitor state
  int cyc, rd_cnt, strb_cnt, ack_cnt, clr_cnt, done_cnt, stall_cnt, viol_cnt;
  int first_rd_cyc, done_cyc;
  int          rq_idx [$];
  logic [31:0] rq_dat [$];
  bit          p_hold;
  logic [31:0] p_data;
  logic [AW-1:0] p_idx;
  int          dcnt;
  logic [31:0] dopa, dopb;

  // Divider result function shared by divider model and reference
  function automatic logic [31:0] divf(input logic [31:0] a, input logic [31:0] b);
    return (a ^ {b[15:0], b[31:16]}) + 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_sum();
    logic [31:0] s;
    s = $urandom;
    if (s[30:23] == 8'h00) s[30:23] = 8'h80;
    return s;
  endfunction

  // Exp buffer: one-cycle read latency
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data <= mem[bus.rd_addr];
      last_addr   <= bus.rd_addr;
    end
  end

  // Divider: latency lat, optional stuck strobe, optional hang on one index
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.div_z_strb <= 1'b0;
      bus.div_z      <= 32'h0;
      dcnt           <= 0;
    end else if (bus.div_clr) begin
      bus.div_z_strb <= 1'b0;
      dcnt           <= 0;
    end else begin
      if (bus.div_z_strb && bus.div_z_ack && !stuck) bus.div_z_strb <= 1'b0;
      if (bus.div_a_strb && bus.div_b_strb) begin
        if (int'(last_addr) != hang_idx) begin
          dopa <= bus.div_a;
          dopb <= bus.div_b;
          if (lat <= 1) begin
            bus.div_z      <= divf(bus.div_a, bus.div_b);
            bus.div_z_strb <= 1'b1;
          end else begin
            dcnt <= lat - 1;
          end
        end
      end else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) begin
          bus.div_z      <= divf(dopa, dopb);
          bus.div_z_strb <= 1'b1;
        end
      end
    end
  end

  // Monitor sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (bus.rd_en) begin
      if (rd_cnt == 0) first_rd_cyc = cyc;
      rd_cnt++;
    end
    if (bus.div_a_strb) strb_cnt++;
    if (bus.div_z_ack) ack_cnt++;
    if (bus.div_clr) clr_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) viol_cnt++;
    end
    if (bus.rd_en && bus.res_vld) viol_cnt++;
    if (bus.div_z_ack && !bus.div_z_strb) viol_cnt++;
    if (p_hold && !rst && !(bus.res_vld && bus.res_data == p_data && bus.res_idx == p_idx))
      viol_cnt++;
    if (bus.res_vld && !bus.res_rdy) stall_cnt++;
    if (bus.res_vld && bus.res_rdy) begin
      rq_idx.push_back(int'(bus.res_idx));
      rq_dat.push_back(bus.res_data);
    end
    p_hold = bus.res_vld && !bus.res_rdy && !rst;
    p_data = bus.res_data;
    p_idx  = bus.res_idx;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_cnt = 0; strb_cnt = 0; ack_cnt = 0; clr_cnt = 0; done_cnt = 0;
    stall_cnt = 0; viol_cnt = 0; first_rd_cyc = 0; done_cyc = 0;
    rq_idx.delete();
    rq_dat.delete();
  endtask

  task automatic do_start(input logic [31:0] s);
    sum   = s;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < int'(N); i++) mem[i] = $urandom;
  endtask

  task automatic run_to_done(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      step();
      case (rdy_mode)
        1: bus.res_rdy = 1'($urandom_range(0, 1));
        2: begin
          if (bus.res_vld && bus.res_idx == AW'(3) && hold_left > 0) begin
            bus.res_rdy = 1'b0;
            hold_left--;
          end else begin
            bus.res_rdy = 1'b1;
          end
        end
        default: bus.res_rdy = 1'b1;
      endcase
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("run_done", 32'(seen), 32'd1);
    step();
    step();
  endtask

  task automatic check_results(input int n_exp, input logic [31:0] s);
    check("res_count", 32'(rq_idx.size()), 32'(n_exp));
    for (int i = 0; i < rq_idx.size() && i < n_exp; i++) begin
      check("res_idx", 32'(rq_idx[i]), 32'(i));
      check("res_data", rq_dat[i], (i == hang_idx) ? 32'h0 : divf(mem[i], s));
    end
  endtask

  initial begin
    logic [31:0] s;
    bit found;
    n_cmp = 0; n_bad = 0; cyc = 0; p_hold = 0;
    lat = 3; stuck = 0; hang_idx = -1; rdy_mode = 0; hold_left = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; sum = 32'h0; bus.res_rdy = 1'b0;
    clear_mon();

    // Reset state
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("rst_div_clr", 32'(bus.div_clr), 32'd0);
    check("rst_strb", 32'({bus.div_a_strb, bus.div_b_strb, bus.div_z_ack}), 32'd0);
    check("rst_div_ab", bus.div_a | bus.div_b, 32'd0);
    check("rst_res", {bus.res_data[30:0], bus.res_vld}, 32'd0);
    rst = 1'b0;
    step();

    // Single run with 1.0..8.0 divided by 2.0
    mem[0] = 32'h3F80_0000; mem[1] = 32'h4000_0000; mem[2] = 32'h4040_0000;
    mem[3] = 32'h4080_0000; mem[4] = 32'h40A0_0000; mem[5] = 32'h40C0_0000;
    mem[6] = 32'h40E0_0000; mem[7] = 32'h4100_0000;
    lat = 3; rdy_mode = 0; bus.res_rdy = 1'b1;
    clear_mon();
    s = 32'h4000_0000;
    do_start(s);
    check("t1_rd_busy", 32'(busy), 32'd1);
    check("t1_rd_en", 32'(bus.rd_en), 32'd1);
    check("t1_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("t1_rd_clr", 32'(bus.div_clr), 32'd1);
    step();
    check("t1_iss_strb", 32'({bus.div_a_strb, bus.div_b_strb}), 32'd3);
    check("t1_iss_a", bus.div_a, mem[0]);
    check("t1_iss_b", bus.div_b, s);
    step();
    check("t1_wait_strb", 32'(bus.div_a_strb), 32'd0);
    check("t1_wait_a_hold", bus.div_a, mem[0]);
    run_to_done(400);
    check_results(int'(N), s);
    check("t1_acks", 32'(ack_cnt), 32'(N));
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_cycles", 32'(done_cyc - first_rd_cyc), 32'(N * 6));
    check("t1_viol", 32'(viol_cnt), 32'd0);

    // Backpressure on index 3
    fill_rand();
    lat = int'($urandom_range(1, 4)); rdy_mode = 2; hold_left = 5;
    clear_mon();
    s = rand_sum();
    do_start(s);
    run_to_done(400);
    check_results(int'(N), s);
    check("t2_stall", 32'(stall_cnt), 32'd5);
    check("t2_rd_cnt", 32'(rd_cnt), 32'(N));
    check("t2_viol", 32'(viol_cnt), 32'd0);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);

    // Divider holds its strobe after each result
    fill_rand();
    lat = int'($urandom_range(1, 4)); rdy_mode = 0; stuck = 1;
    clear_mon();
    s = rand_sum();
    do_start(s);
    run_to_done(400);
    check_results(int'(N), s);
    check("t3_clr_cnt", 32'(clr_cnt), 32'(N));
    check("t3_acks", 32'(ack_cnt), 32'(N));
    check("t3_err", 32'(err), 32'd0);
    stuck = 0;

    // Divider never answers on index 2
    fill_rand();
    lat = 2; hang_idx = 2;
    clear_mon();
    s = rand_sum();
    do_start(s);
    run_to_done(600);
    check_results(int'(N), s);
    check("t4_err", 32'(err), 32'd1);
    check("t4_acks", 32'(ack_cnt), 32'(N - 1));
    check("t4_cycles", 32'(done_cyc - first_rd_cyc), 32'(7 * 5 + 2 + TIMEOUT + 1));
    hang_idx = -1;
    clear_mon();
    s = rand_sum();
    do_start(s);
    check("t4_err_clr", 32'(err), 32'd0);
    run_to_done(400);
    check_results(int'(N), s);
    check("t4_err_end", 32'(err), 32'd0);

    // Zero divisor
    clear_mon();
    do_start(32'h0000_0000);
    check("t5_done", 32'(done), 32'd1);
    check("t5_err", 32'(err), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (4) step();
    check("t5_rd_cnt", 32'(rd_cnt), 32'd0);
    check("t5_strb_cnt", 32'(strb_cnt), 32'd0);
    check("t5_res_cnt", 32'(rq_idx.size()), 32'd0);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);

    // Abort ignored in IDLE
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t6_idle_abort", 32'(busy), 32'd0);

    // Abort in WAIT of index 5
    fill_rand();
    lat = 6; rdy_mode = 0;
    clear_mon();
    s = rand_sum();
    do_start(s);
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (bus.rd_en && bus.rd_addr == AW'(5)) begin
        found = 1'b1;
        break;
      end
      step();
      bus.res_rdy = 1'b1;
    end
    check("t6_reach_idx5", 32'(found), 32'd1);
    step();
    step();
    check("t6_in_wait", 32'({busy, bus.div_a_strb}), 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_res_vld", 32'(bus.res_vld), 32'd0);
    check("t6_div_clr", 32'(bus.div_clr), 32'd1);
    repeat (10) step();
    check("t6_no_done", 32'(done_cnt), 32'd0);
    check("t6_rd_cnt", 32'(rd_cnt), 32'd6);
    check_results(5, s);

    // Start with abort together, then async reset while in OUT
    fill_rand();
    lat = 2; bus.res_rdy = 1'b0;
    clear_mon();
    s = rand_sum();
    abort = 1'b1;
    do_start(s);
    abort = 1'b0;
    check("t7_start_wins", 32'(busy), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.res_vld) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t7_reach_out", 32'(found), 32'd1);
    check("t7_out_data", bus.res_data, divf(mem[0], s));
    #2 rst = 1'b1;
    #1;
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_vld", 32'(bus.res_vld), 32'd0);
    check("t7_rst_data", bus.res_data, 32'd0);
    step();
    rst = 1'b0;
    repeat (5) step();
    check("t7_no_done", 32'(done_cnt), 32'd0);

    // Randomised runs with random backpressure after the reset
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      lat = int'($urandom_range(1, 6)); rdy_mode = 1;
      clear_mon();
      s = rand_sum();
      do_start(s);
      run_to_done(800);
      check_results(int'(N), s);
      check("t8_acks", 32'(ack_cnt), 32'(N));
      check("t8_done_cnt", 32'(done_cnt), 32'd1);
      check("t8_err", 32'(err), 32'd0);
      check("t8_viol", 32'(viol_cnt), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
